// File: rtl/adc_spi_responder_pkg.sv
// adc_spi_pkg: opcodes, frame constants and FSM encoding shared with the FPGA-side ADC controller
package adc_spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ = 4'h2;
  localparam logic [3:0] OP_CONVERT = 4'h3;
  localparam logic [15:0] ERR_RESPONSE = 16'hFFFF;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/adc_spi_responder_if.sv
// adc_spi_responder_if: ADC serial pins; master = FPGA controller, slave = emulated chip
interface adc_spi_responder_if;
  logic adc_sclk;
  logic adc_cs_n;
  logic adc_din;
  logic adc_rst_n;
  logic adc_dout;
  modport master(output adc_sclk, adc_cs_n, adc_din, adc_rst_n, input adc_dout);
  modport slave(input adc_sclk, adc_cs_n, adc_din, adc_rst_n, output adc_dout);
endinterface

// File: rtl/adc_spi_responder_spi_pin_sync.sv
// spi_pin_sync: STAGES-deep synchronizer with optional rise/fall detection on the synchronized level
// ports: clk, rst (async active-low), d (async pin) -> q (synced), rise/fall (one-clk pulses, 0 when EDGES=0)
module spi_pin_sync #(
  parameter int STAGES = 2,
  parameter bit INIT = 1'b0,
  parameter bit EDGES = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sr <= {STAGES{INIT}};
      prev <= INIT;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  assign q = sr[STAGES-1];
  assign rise = EDGES && q && !prev;
  assign fall = EDGES && !q && prev;
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI slave emulating the biosensor ADC; 16-bit commands, small register file, response one frame later
// ports: clk, rst (async active-low), spi (slave pins), sample_data in; cmd_word, frame_done pulse, sticky protocol_err out
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter logic [15:0] RAMP_STEP = 16'd1
) (
  input  logic clk,
  input  logic rst,
  adc_spi_responder_if.slave spi,
  input  logic [15:0] sample_data,
  output logic [15:0] cmd_word,
  output logic frame_done,
  output logic protocol_err
);
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, din_s, srst_n;
  logic unused_sclk_q, unused_cs_q;
  logic [1:0] unused_din_edge, unused_rst_edge;
  spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0), .EDGES(1'b1)) u_sclk (
    .clk(clk), .rst(rst), .d(spi.adc_sclk), .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1), .EDGES(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(spi.adc_cs_n), .q(unused_cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0), .EDGES(1'b0)) u_din (
    .clk(clk), .rst(rst), .d(spi.adc_din), .q(din_s), .rise(unused_din_edge[0]), .fall(unused_din_edge[1]));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1), .EDGES(1'b0)) u_rst (
    .clk(clk), .rst(rst), .d(spi.adc_rst_n), .q(srst_n), .rise(unused_rst_edge[0]), .fall(unused_rst_edge[1]));
  state_t state;
  logic [7:0] regs [16];
  logic [15:0] ramp, resp, tx, rx;
  logic [4:0] bit_cnt;
  logic dout;
  logic [3:0] op, addr;
  logic [7:0] data;
  assign {op, addr, data} = rx;
  assign spi.adc_dout = dout;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      regs <= '{default: '0};
      ramp <= '0;
      resp <= '0;
      tx <= '0;
      rx <= '0;
      bit_cnt <= '0;
      dout <= 1'b0;
      cmd_word <= '0;
      frame_done <= 1'b0;
      protocol_err <= 1'b0;
    end else if (!srst_n) begin
      // chip soft reset: silently abandons any frame; cmd_word keeps the last good command
      state <= ST_IDLE;
      regs <= '{default: '0};
      ramp <= '0;
      resp <= '0;
      tx <= '0;
      bit_cnt <= '0;
      dout <= 1'b0;
      frame_done <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE:
          if (cs_fall) begin
            tx <= resp;
            dout <= resp[15];
            bit_cnt <= '0;
            state <= ST_SHIFT;
          end
        ST_SHIFT: begin
          // sclk edges are handled in the same clk as a coincident cs_n rise, so they count
          if (sclk_rise) begin
            rx <= {rx[14:0], din_s};
            bit_cnt <= bit_cnt + (bit_cnt != 5'd17 ? 5'd1 : 5'd0);
          end
          if (sclk_fall) begin
            tx <= {tx[14:0], 1'b0};
            dout <= tx[14];
          end
          if (cs_rise) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          if (bit_cnt == 5'(FRAME_BITS)) begin
            cmd_word <= rx;
            frame_done <= 1'b1;
            case (op)
              OP_NOP: resp <= '0;
              OP_WRITE: begin
                if (addr != 4'hF) regs[addr] <= data;
                resp <= rx;
              end
              OP_READ: resp <= {OP_READ, addr, addr == 4'hF ? ID_VALUE : regs[addr]};
              OP_CONVERT:
                if (regs[0][0]) begin
                  resp <= ramp;
                  ramp <= ramp + RAMP_STEP;
                end else resp <= sample_data;
              default: resp <= ERR_RESPONSE;
            endcase
          end else if (bit_cnt != '0) begin
            protocol_err <= 1'b1;
            resp <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: scoreboard bench driving SPI frames and checking responses, pulses and error flag
module tb_adc_spi_responder;
  localparam logic [15:0] STEP = 16'h5555;
  localparam int H = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] sd = '0;
  logic [15:0] cw;
  logic fd, perr;
  adc_spi_responder_if spi();
  adc_spi_responder #(.SYNC_STAGES(2), .ID_VALUE(8'hA5), .RAMP_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .spi(spi), .sample_data(sd), .cmd_word(cw), .frame_done(fd), .protocol_err(perr));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_err = 0;
  int fd_cnt = 0;
  always @(posedge clk) if (fd) fd_cnt <= fd_cnt + 1;
  logic [15:0] sb [$];
  logic [7:0] mregs [16];
  logic [15:0] mramp = '0;
  logic mperr = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic run_frame(input logic [15:0] cmd, input int n, input bit abort);
    logic [31:0] got, full;
    logic [15:0] exp, nxt;
    logic [3:0] a;
    int fd0;
    got = '0;
    fd0 = fd_cnt;
    spi.adc_cs_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi.adc_din = (i < 16) ? cmd[15-i] : 1'b0;
      wait_clk(H);
      got = {got[30:0], spi.adc_dout};
      spi.adc_sclk = 1'b1;
      wait_clk(H);
      spi.adc_sclk = 1'b0;
    end
    wait_clk(H);
    if (abort) begin
      spi.adc_rst_n = 1'b0;
      wait_clk(4);
      spi.adc_rst_n = 1'b1;
      wait_clk(6);
    end
    spi.adc_cs_n = 1'b1;
    wait_clk(10);
    if (abort) begin
      mregs = '{default: '0};
      mramp = '0;
      mperr = 1'b0;
      sb.delete();
      sb.push_back(16'h0000);
      chk("fdone_abort", fd_cnt - fd0, 0);
    end else if (n == 0) begin
      chk("fdone_empty", fd_cnt - fd0, 0);
    end else begin
      exp = sb.pop_front();
      full = {exp, 16'h0000} >> (32 - n);
      chk("resp", got, full);
      if (n != 16) begin
        mperr = 1'b1;
        sb.push_back(16'h0000);
        chk("fdone_bad", fd_cnt - fd0, 0);
      end else begin
        a = cmd[11:8];
        case (cmd[15:12])
          4'h0: nxt = 16'h0000;
          4'h1: begin
            if (a != 4'hF) mregs[a] = cmd[7:0];
            nxt = cmd;
          end
          4'h2: nxt = {4'h2, a, a == 4'hF ? 8'hA5 : mregs[a]};
          4'h3:
            if (mregs[0][0]) begin
              nxt = mramp;
              mramp = mramp + STEP;
            end else nxt = sd;
          default: nxt = 16'hFFFF;
        endcase
        sb.push_back(nxt);
        chk("fdone", fd_cnt - fd0, 1);
        chk("cmd_word", cw, cmd);
      end
    end
    chk("perr", perr, mperr);
  endtask
  initial begin
    mregs = '{default: '0};
    spi.adc_sclk = 1'b0;
    spi.adc_cs_n = 1'b1;
    spi.adc_din = 1'b0;
    spi.adc_rst_n = 1'b1;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(3);
    chk("rst_dout", spi.adc_dout, 0);
    chk("rst_cmd", cw, 0);
    chk("rst_fdone", fd, 0);
    chk("rst_perr", perr, 0);
    sb.push_back(16'h0000);
    run_frame(16'h1305, 16, 0);
    run_frame(16'h2300, 16, 0);
    run_frame(16'h0000, 16, 0);
    run_frame(16'h2F00, 16, 0);
    run_frame(16'h1F00, 16, 0);
    run_frame(16'h2F00, 16, 0);
    run_frame(16'h1001, 16, 0);
    repeat (5) run_frame(16'h3000, 16, 0);
    run_frame(16'h1000, 16, 0);
    sd = 16'hBEEF;
    run_frame(16'h3000, 16, 0);
    run_frame(16'h7123, 16, 0);
    run_frame(16'h0000, 16, 0);
    run_frame(16'h2300, 9, 0);
    run_frame(16'h0000, 16, 0);
    run_frame(16'h1455, 17, 0);
    run_frame(16'h0000, 0, 0);
    run_frame(16'h2400, 16, 0);
    run_frame(16'h1277, 16, 0);
    run_frame(16'h2200, 8, 1);
    run_frame(16'h2200, 16, 0);
    run_frame(16'h0000, 16, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
